// File: rtl/multi_item_select_if.sv
// ---------------------------------------------------------------------------
// multi_item_select_if
//   Bundles the request, consumer and status signals of multi_item_select.
//   The master modport is the environment: request channels plus the
//   dispense/payment consumer. The slave modport is the selector itself.
//
//   item_select        NUM_CH*ITEM_ADDR_WIDTH  packed per-channel addresses
//   item_select_valid  NUM_CH                  per-channel request valid
//   item_select_ready  NUM_CH                  per-channel grant (one-hot or 0)
//   item_selected      ITEM_ADDR_WIDTH         address at the FIFO head
//   item_channel       CH_W                    source channel at the FIFO head
//   selection_valid    1                       FIFO not empty
//   selection_ready    1                       consumer pops the head entry
//   fifo_count         CNT_W                   occupied entries
//   sel_error          1                       pulse: out-of-range request dropped
//   err_channel        CH_W                    channel of the last dropped request
// ---------------------------------------------------------------------------
interface multi_item_select_if #(
  parameter int ITEM_ADDR_WIDTH = 10,
  parameter int NUM_CH          = 4,
  parameter int DEPTH           = 4
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [NUM_CH*ITEM_ADDR_WIDTH-1:0] item_select;
  logic [NUM_CH-1:0]                 item_select_valid;
  logic [NUM_CH-1:0]                 item_select_ready;
  logic [ITEM_ADDR_WIDTH-1:0]        item_selected;
  logic [CH_W-1:0]                   item_channel;
  logic                              selection_valid;
  logic                              selection_ready;
  logic [CNT_W-1:0]                  fifo_count;
  logic                              sel_error;
  logic [CH_W-1:0]                   err_channel;

  modport master (
    output item_select, item_select_valid, selection_ready,
    input  item_select_ready, item_selected, item_channel, selection_valid,
           fifo_count, sel_error, err_channel
  );

  modport slave (
    input  item_select, item_select_valid, selection_ready,
    output item_select_ready, item_selected, item_channel, selection_valid,
           fifo_count, sel_error, err_channel
  );
endinterface

// File: rtl/multi_item_select.sv
// ---------------------------------------------------------------------------
// multi_item_select
//   Multi-channel item selector. NUM_CH request ports are arbitrated
//   round-robin; the granted address is range-checked against MAX_ITEM and,
//   if legal, queued together with its channel number in a first-word-fall-
//   through FIFO of DEPTH entries. Illegal addresses are dropped and flagged
//   with a one-cycle sel_error pulse plus a sticky err_channel.
//
//   Ports:
//     clk   rising-edge clock
//     rstn  synchronous active-low reset
//     bus   multi_item_select_if.slave (requests, consumer, status)
//
//   Optional feature (macro SELECT_DEDUP_EN): an accepted legal request that
//   repeats the newest queued entry (same channel and address) is dropped
//   silently instead of being queued again.
// ---------------------------------------------------------------------------
module multi_item_select #(
  parameter int ITEM_ADDR_WIDTH = 10,
  parameter int NUM_CH          = 4,
  parameter int DEPTH           = 4,
  parameter int MAX_ITEM        = 999
) (
  input logic                clk,
  input logic                rstn,
  multi_item_select_if.slave bus
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  typedef struct packed {
    logic [CH_W-1:0]            ch;
    logic [ITEM_ADDR_WIDTH-1:0] addr;
  } entry_t;

  // State
  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             sel_error_q, sel_error_d;
  logic [CH_W-1:0]  err_channel_q, err_channel_d;

  // Unpack the channel addresses once so the winner can be indexed directly.
  logic [ITEM_ADDR_WIDTH-1:0] ch_addr [NUM_CH];
  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign ch_addr[g] = bus.item_select[g*ITEM_ADDR_WIDTH +: ITEM_ADDR_WIDTH];
  end

  // -------------------------------------------------------------------------
  // Round-robin arbiter: first valid channel at or after rr_ptr wins.
  // -------------------------------------------------------------------------
  logic                       win_found;
  logic [CH_W-1:0]            win_ch;
  logic [CH_W-1:0]            cand;
  logic [ITEM_ADDR_WIDTH-1:0] win_addr;

  // NOTE: every always_comb output gets a default before any condition, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    win_found = 1'b0;
    win_ch    = '0;
    cand      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = CH_W'((int'(rr_ptr_q) + k) % NUM_CH);
      if (!win_found && bus.item_select_valid[cand]) begin
        win_found = 1'b1;
        win_ch    = cand;
      end
    end
    win_addr = ch_addr[win_ch];
  end

  // Grant never looks at selection_ready: a full FIFO refuses pushes even
  // when the head is popped in the same cycle, keeping ready free of any
  // combinational path from the consumer.
  logic full;
  logic accept;
  logic in_range;
  logic is_dup;
  logic push;
  logic pop;
  logic drop_err;

  assign full     = (cnt_q == FULL_CNT);
  assign accept   = rstn && win_found && !full;
  assign in_range = (int'(win_addr) <= MAX_ITEM);

`ifdef SELECT_DEDUP_EN
  // Duplicate check against the newest entry as it stands before the edge;
  // a same-cycle pop of that entry does not rescue the duplicate.
  logic [PTR_W-1:0] newest_ptr;
  assign newest_ptr = (wr_ptr_q == '0) ? LAST_PTR : wr_ptr_q - 1'b1;
  assign is_dup     = (cnt_q != '0)
                   && (mem_q[newest_ptr].ch   == win_ch)
                   && (mem_q[newest_ptr].addr == win_addr);
`else
  assign is_dup = 1'b0;
`endif

  assign push     = accept && in_range && !is_dup;
  assign drop_err = accept && !in_range;
  assign pop      = (cnt_q != '0) && bus.selection_ready;

  always_comb begin
    bus.item_select_ready = '0;
    if (accept) bus.item_select_ready[win_ch] = 1'b1;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    cnt_d         = cnt_q;
    rr_ptr_d      = rr_ptr_q;
    err_channel_d = err_channel_q;
    sel_error_d   = drop_err;

    // Pointer moves past the winner on any accept, including dropped ones.
    if (accept) rr_ptr_d = CH_W'((int'(win_ch) + 1) % NUM_CH);

    if (drop_err) err_channel_d = win_ch;

    if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      rr_ptr_q      <= '0;
      sel_error_q   <= 1'b0;
      err_channel_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      sel_error_q   <= sel_error_d;
      err_channel_q <= err_channel_d;
    end
  end

  // NOTE: the storage array has no reset; occupancy is tracked by cnt_q and
  // the head is masked while empty, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{ch: win_ch, addr: win_addr};
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  entry_t head;
  assign head = mem_q[rd_ptr_q];

  assign bus.selection_valid = (cnt_q != '0);
  assign bus.item_selected   = bus.selection_valid ? head.addr : '0;
  assign bus.item_channel    = bus.selection_valid ? head.ch   : '0;
  assign bus.fifo_count      = cnt_q;
  assign bus.sel_error       = sel_error_q;
  assign bus.err_channel     = err_channel_q;

endmodule

// File: tb/tb_multi_item_select.sv
// ---------------------------------------------------------------------------
// tb_multi_item_select
//   Directed vector table (with hand-derived expectations) followed by a
//   randomized run checked against a queue-based reference model.
//   Build with +define+SELECT_DEDUP_EN to exercise the duplicate filter.
// ---------------------------------------------------------------------------
module tb_multi_item_select;
  localparam int AW  = 10;
  localparam int NC  = 4;
  localparam int DP  = 4;
  localparam int MAX = 999;
`ifdef SELECT_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  multi_item_select_if #(.ITEM_ADDR_WIDTH(AW), .NUM_CH(NC), .DEPTH(DP)) bus ();

  multi_item_select #(
    .ITEM_ADDR_WIDTH(AW), .NUM_CH(NC), .DEPTH(DP), .MAX_ITEM(MAX)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Directed vectors
  // -------------------------------------------------------------------------
  typedef struct {
    logic       rstn;
    logic [3:0] valid;
    logic [9:0] a0, a1, a2, a3;
    logic       sr;
    logic [3:0] e_ready;
    logic       e_sv;
    logic [9:0] e_item;
    logic [1:0] e_ch;
    logic [2:0] e_cnt;
    logic       e_err;
    logic [1:0] e_errch;
  } vec_t;

  vec_t tbl[$];

  task automatic drive(input logic r, input logic [3:0] v, input logic [9:0] a0,
                       input logic [9:0] a1, input logic [9:0] a2, input logic [9:0] a3,
                       input logic sr);
    rstn                  = r;
    bus.item_select_valid = v;
    bus.item_select       = {a3, a2, a1, a0};
    bus.selection_ready   = sr;
  endtask

  task automatic apply(input vec_t v, input int idx);
    string t;
    t = $sformatf("vec%0d", idx);
    @(negedge clk);
    drive(v.rstn, v.valid, v.a0, v.a1, v.a2, v.a3, v.sr);
    #1 check({t, ".ready"}, 32'(bus.item_select_ready), 32'(v.e_ready));
    @(posedge clk);
    #1;
    check({t, ".sel_valid"}, 32'(bus.selection_valid), 32'(v.e_sv));
    check({t, ".item"},      32'(bus.item_selected),   32'(v.e_item));
    check({t, ".channel"},   32'(bus.item_channel),    32'(v.e_ch));
    check({t, ".count"},     32'(bus.fifo_count),      32'(v.e_cnt));
    check({t, ".sel_error"}, 32'(bus.sel_error),       32'(v.e_err));
    check({t, ".err_ch"},    32'(bus.err_channel),     32'(v.e_errch));
  endtask

  // -------------------------------------------------------------------------
  // Reference model: ordered queue of {channel, address} plus rotating start
  // -------------------------------------------------------------------------
  typedef struct packed {
    logic [1:0] ch;
    logic [9:0] addr;
  } ent_t;

  ent_t m_q[$];
  int   m_rr    = 0;
  bit   m_err   = 1'b0;
  int   m_errch = 0;

  function automatic logic [9:0] addr_of(input logic [39:0] packed_a, input int ch);
    logic [39:0] tmp;
    tmp = packed_a >> (ch * AW);
    return tmp[9:0];
  endfunction

  // Which channel the rules grant this cycle, or -1 for none.
  function automatic int model_winner(input logic r, input logic [3:0] v);
    if (!r || m_q.size() >= DP) return -1;
    for (int k = 0; k < NC; k++) begin
      if (v[(m_rr + k) % NC]) return (m_rr + k) % NC;
    end
    return -1;
  endfunction

  task automatic model_commit(input logic r, input logic [3:0] v, input logic [39:0] a,
                              input logic sr);
    int         w;
    logic [9:0] ad;
    bit         do_push, do_pop, dup;
    if (!r) begin
      m_q.delete();
      m_rr    = 0;
      m_err   = 1'b0;
      m_errch = 0;
      return;
    end
    w       = model_winner(r, v);
    do_pop  = (m_q.size() != 0) && sr;
    do_push = 1'b0;
    m_err   = 1'b0;
    if (w >= 0) begin
      ad   = addr_of(a, w);
      m_rr = (w + 1) % NC;
      dup  = DEDUP && (m_q.size() != 0) && (m_q[$].ch == 2'(w)) && (m_q[$].addr == ad);
      if (int'(ad) > MAX) begin
        m_err   = 1'b1;
        m_errch = w;
      end else if (!dup) begin
        do_push = 1'b1;
      end
    end
    if (do_pop) void'(m_q.pop_front());
    if (do_push) m_q.push_back('{ch: 2'(w), addr: ad});
  endtask

  function automatic logic [9:0] rnd_addr();
    case ($urandom_range(0, 7))
      0:       return 10'($urandom_range(1000, 1023));
      1:       return 10'd999;
      2:       return 10'd0;
      default: return 10'($urandom_range(0, 5));
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // Watchdog
  // -------------------------------------------------------------------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  initial begin
    drive(1'b0, 4'h0, '0, '0, '0, '0, 1'b0);

    //          rstn valid a0      a1      a2      a3      sr    rdy sv item    ch cnt err ech
    tbl.push_back('{0, 4'hF, 10'h001, 10'h002, 10'h003, 10'h004, 1, 4'h0, 0, 10'h000, 0, 0, 0, 0});
    tbl.push_back('{0, 4'hF, 10'h001, 10'h002, 10'h003, 10'h004, 1, 4'h0, 0, 10'h000, 0, 0, 0, 0});
    // first accept and latency
    tbl.push_back('{1, 4'h1, 10'h123, 10'h000, 10'h000, 10'h000, 0, 4'h1, 1, 10'h123, 0, 1, 0, 0});
    tbl.push_back('{1, 4'h0, 10'h000, 10'h000, 10'h000, 10'h000, 1, 4'h0, 0, 10'h000, 0, 0, 0, 0});
    // three channels competing, pointer at 1
    tbl.push_back('{1, 4'h7, 10'h001, 10'h002, 10'h003, 10'h000, 0, 4'h2, 1, 10'h002, 1, 1, 0, 0});
    tbl.push_back('{1, 4'h5, 10'h001, 10'h002, 10'h003, 10'h000, 0, 4'h4, 1, 10'h002, 1, 2, 0, 0});
    tbl.push_back('{1, 4'h1, 10'h001, 10'h002, 10'h003, 10'h000, 0, 4'h1, 1, 10'h002, 1, 3, 0, 0});
    tbl.push_back('{1, 4'h0, 10'h000, 10'h000, 10'h000, 10'h000, 1, 4'h0, 1, 10'h003, 2, 2, 0, 0});
    tbl.push_back('{1, 4'h0, 10'h000, 10'h000, 10'h000, 10'h000, 1, 4'h0, 1, 10'h001, 0, 1, 0, 0});
    tbl.push_back('{1, 4'h0, 10'h000, 10'h000, 10'h000, 10'h000, 1, 4'h0, 0, 10'h000, 0, 0, 0, 0});
    // fill from ch1 until full
    tbl.push_back('{1, 4'h2, 10'h000, 10'h005, 10'h000, 10'h000, 0, 4'h2, 1, 10'h005, 1, 1, 0, 0});
    tbl.push_back('{1, 4'h2, 10'h000, 10'h006, 10'h000, 10'h000, 0, 4'h2, 1, 10'h005, 1, 2, 0, 0});
    tbl.push_back('{1, 4'h2, 10'h000, 10'h007, 10'h000, 10'h000, 0, 4'h2, 1, 10'h005, 1, 3, 0, 0});
    tbl.push_back('{1, 4'h2, 10'h000, 10'h008, 10'h000, 10'h000, 0, 4'h2, 1, 10'h005, 1, 4, 0, 0});
    tbl.push_back('{1, 4'h2, 10'h000, 10'h009, 10'h000, 10'h000, 0, 4'h0, 1, 10'h005, 1, 4, 0, 0});
    // full with pop: still no grant in the same cycle
    tbl.push_back('{1, 4'h2, 10'h000, 10'h009, 10'h000, 10'h000, 1, 4'h0, 1, 10'h006, 1, 3, 0, 0});
    tbl.push_back('{1, 4'h2, 10'h000, 10'h009, 10'h000, 10'h000, 0, 4'h2, 1, 10'h006, 1, 4, 0, 0});
    tbl.push_back('{1, 4'h0, 10'h000, 10'h000, 10'h000, 10'h000, 1, 4'h0, 1, 10'h007, 1, 3, 0, 0});
    // out-of-range, back-to-back pulses
    tbl.push_back('{1, 4'h8, 10'h000, 10'h000, 10'h000, 10'h3E8, 0, 4'h8, 1, 10'h007, 1, 3, 1, 3});
    tbl.push_back('{1, 4'h8, 10'h000, 10'h000, 10'h000, 10'h3E9, 0, 4'h8, 1, 10'h007, 1, 3, 1, 3});
    tbl.push_back('{1, 4'h1, 10'h3FF, 10'h000, 10'h000, 10'h000, 0, 4'h1, 1, 10'h007, 1, 3, 1, 0});
    tbl.push_back('{1, 4'h4, 10'h000, 10'h000, 10'h3F0, 10'h000, 0, 4'h4, 1, 10'h007, 1, 3, 1, 2});
    tbl.push_back('{1, 4'h0, 10'h000, 10'h000, 10'h000, 10'h000, 0, 4'h0, 1, 10'h007, 1, 3, 0, 2});
    // mid-operation reset, then refill
    tbl.push_back('{0, 4'h2, 10'h000, 10'h00A, 10'h000, 10'h000, 1, 4'h0, 0, 10'h000, 0, 0, 0, 0});
    tbl.push_back('{1, 4'h3, 10'h0AA, 10'h0BB, 10'h000, 10'h000, 0, 4'h1, 1, 10'h0AA, 0, 1, 0, 0});
    tbl.push_back('{1, 4'h2, 10'h0AA, 10'h0BB, 10'h000, 10'h000, 1, 4'h2, 1, 10'h0BB, 1, 1, 0, 0});
    tbl.push_back('{1, 4'h0, 10'h000, 10'h000, 10'h000, 10'h000, 1, 4'h0, 0, 10'h000, 0, 0, 0, 0});
    // push into empty with ready high; boundary address 999 accepted
    tbl.push_back('{1, 4'h4, 10'h000, 10'h000, 10'h3E7, 10'h000, 1, 4'h4, 1, 10'h3E7, 2, 1, 0, 0});
    // duplicate handling
    tbl.push_back('{0, 4'h0, 10'h000, 10'h000, 10'h000, 10'h000, 0, 4'h0, 0, 10'h000, 0, 0, 0, 0});
    tbl.push_back('{1, 4'h4, 10'h000, 10'h000, 10'h010, 10'h000, 0, 4'h4, 1, 10'h010, 2, 1, 0, 0});
    tbl.push_back('{1, 4'h0, 10'h000, 10'h000, 10'h000, 10'h000, 0, 4'h0, 1, 10'h010, 2, 1, 0, 0});
    tbl.push_back('{1, 4'h4, 10'h000, 10'h000, 10'h010, 10'h000, 0, 4'h4, 1, 10'h010, 2,
                    DEDUP ? 3'd1 : 3'd2, 0, 0});
    tbl.push_back('{1, 4'h4, 10'h000, 10'h000, 10'h010, 10'h000, 1, 4'h4,
                    DEDUP ? 1'b0 : 1'b1, DEDUP ? 10'h000 : 10'h010, DEDUP ? 2'd0 : 2'd2,
                    DEDUP ? 3'd0 : 3'd2, 0, 0});
    tbl.push_back('{1, 4'h4, 10'h000, 10'h000, 10'h010, 10'h000, 0, 4'h4, 1, 10'h010, 2,
                    DEDUP ? 3'd1 : 3'd3, 0, 0});

    foreach (tbl[i]) apply(tbl[i], i);

    // -----------------------------------------------------------------------
    // Randomized run against the reference model
    // -----------------------------------------------------------------------
    for (int c = 0; c < 1500; c++) begin
      logic        r, sr;
      logic [3:0]  v;
      logic [39:0] a;
      int          w;
      logic [3:0]  exp_ready;
      @(negedge clk);
      r  = (c == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
      v  = 4'($urandom);
      // alternate consumer pressure so the FIFO visits both empty and full
      sr = ((c / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      a  = {rnd_addr(), rnd_addr(), rnd_addr(), rnd_addr()};
      drive(r, v, a[9:0], a[19:10], a[29:20], a[39:30], sr);
      w         = model_winner(r, v);
      exp_ready = (w >= 0) ? 4'(1 << w) : 4'h0;
      #1 check("rnd.ready", 32'(bus.item_select_ready), 32'(exp_ready));
      model_commit(r, v, a, sr);
      @(posedge clk);
      #1;
      check("rnd.count",     32'(bus.fifo_count),      32'(m_q.size()));
      check("rnd.sel_valid", 32'(bus.selection_valid), 32'(m_q.size() != 0));
      check("rnd.item",      32'(bus.item_selected),   32'((m_q.size() != 0) ? m_q[0].addr : 10'h0));
      check("rnd.channel",   32'(bus.item_channel),    32'((m_q.size() != 0) ? m_q[0].ch : 2'h0));
      check("rnd.sel_error", 32'(bus.sel_error),       32'(m_err));
      check("rnd.err_ch",    32'(bus.err_channel),     32'(m_errch));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
